// File: rtl/ysyx_rnu.sv
// ysyx_rnu: rename unit between the IDU and the ROB/issue stage.
// It allocates a ROB tag per accepted instruction, resolves source producer
// tags through a register alias table (RAT), and presents the renamed
// instruction from a one-entry output register.
//
// Ports:
//   clock, reset                 clock; synchronous active-low reset
//   idu_valid/idu_ready          decode handshake (idu_ready is combinational)
//   idu_rd/rs1/rs2, idu_wen      architectural indices and rd write enable
//   idu_payload                  remaining decode fields, passed through untouched
//   rnu_valid/rnu_ready          dispatch handshake
//   rnu_qj/qk                    producer tags of rs1/rs2 (0 = operand ready)
//   rnu_dest                     allocated ROB tag (1..ROB_SIZE)
//   rnu_rd/wen/payload           registered copies of the inputs
//   cmt_valid/rd/dest            ROB commit of one entry
//   flush                        pipeline flush (mispredict/trap)
//   perf_renamed, perf_full_stall  (only with YSYX_RNU_PERF_EN) 32-bit counters
//
// Optional feature macro: YSYX_RNU_PERF_EN adds the two performance counters.

`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 8
`endif

module ysyx_rnu #(
  parameter int unsigned RLEN     = `YSYX_REG_LEN,
  parameter int unsigned XLEN     = `YSYX_XLEN,
  parameter int unsigned ROB_SIZE = `YSYX_ROB_SIZE,
  parameter int unsigned PLEN     = 4 * XLEN + 32,
  localparam int unsigned TW      = $clog2(ROB_SIZE) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            idu_valid,
  output logic            idu_ready,
  input  logic [RLEN-1:0] idu_rd,
  input  logic [RLEN-1:0] idu_rs1,
  input  logic [RLEN-1:0] idu_rs2,
  input  logic            idu_wen,
  input  logic [PLEN-1:0] idu_payload,
  output logic            rnu_valid,
  input  logic            rnu_ready,
  output logic [TW-1:0]   rnu_qj,
  output logic [TW-1:0]   rnu_qk,
  output logic [TW-1:0]   rnu_dest,
  output logic [RLEN-1:0] rnu_rd,
  output logic            rnu_wen,
  output logic [PLEN-1:0] rnu_payload,
  input  logic            cmt_valid,
  input  logic [RLEN-1:0] cmt_rd,
  input  logic [TW-1:0]   cmt_dest,
  input  logic            flush
`ifdef YSYX_RNU_PERF_EN
  ,
  output logic [31:0]     perf_renamed,
  output logic [31:0]     perf_full_stall
`endif
);

  localparam int unsigned NREG = 1 << RLEN;

  logic            rat_busy_q [NREG];
  logic            rat_busy_d [NREG];
  logic [TW-1:0]   rat_tag_q  [NREG];
  logic [TW-1:0]   rat_tag_d  [NREG];
  logic [TW-1:0]   tail_q, tail_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [TW-1:0]   qj_q, qj_d, qk_q, qk_d, dest_q, dest_d;
  logic [RLEN-1:0] rd_q, rd_d;
  logic            wen_q, wen_d;
  logic [PLEN-1:0] pay_q, pay_d;

  logic            accept_c;
  logic            rob_full_c;
  logic [TW-1:0]   qj_c, qk_c;

  assign rob_full_c = (cnt_q >= TW'(ROB_SIZE));
  assign idu_ready  = reset && (!out_valid_q || rnu_ready) && !rob_full_c && !flush;
  assign accept_c   = idu_valid && idu_ready;

  // Source lookup; a same-cycle commit of the producer makes the operand ready.
  always_comb begin
    qj_c = '0;
    qk_c = '0;
    if (idu_rs1 != '0 && rat_busy_q[idu_rs1] &&
        !(cmt_valid && cmt_dest == rat_tag_q[idu_rs1]))
      qj_c = rat_tag_q[idu_rs1];
    if (idu_rs2 != '0 && rat_busy_q[idu_rs2] &&
        !(cmt_valid && cmt_dest == rat_tag_q[idu_rs2]))
      qk_c = rat_tag_q[idu_rs2];
  end

  // Next-state: flush first, then commit clear, then the accept write (which wins).
  always_comb begin
    rat_busy_d  = rat_busy_q;
    rat_tag_d   = rat_tag_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    dest_d      = dest_q;
    rd_d        = rd_q;
    wen_d       = wen_q;
    pay_d       = pay_q;

    if (flush) begin
      for (int i = 0; i < int'(NREG); i++) rat_busy_d[i] = 1'b0;
      cnt_d       = '0;
      tail_d      = TW'(1);
      out_valid_d = 1'b0;
    end else begin
      if (cmt_valid && rat_busy_q[cmt_rd] && rat_tag_q[cmt_rd] == cmt_dest)
        rat_busy_d[cmt_rd] = 1'b0;

      if (accept_c) begin
        if (idu_wen && idu_rd != '0) begin
          rat_busy_d[idu_rd] = 1'b1;
          rat_tag_d[idu_rd]  = tail_q;
        end
        tail_d      = (tail_q == TW'(ROB_SIZE)) ? TW'(1) : tail_q + TW'(1);
        out_valid_d = 1'b1;
        qj_d        = qj_c;
        qk_d        = qk_c;
        dest_d      = tail_q;
        rd_d        = idu_rd;
        wen_d       = idu_wen;
        pay_d       = idu_payload;
      end else if (rnu_ready) begin
        out_valid_d = 1'b0;
      end

      // Commit on an empty window is illegal; it is ignored rather than underflowing.
      case ({accept_c, cmt_valid && cnt_q != '0})
        2'b10:   cnt_d = cnt_q + TW'(1);
        2'b01:   cnt_d = cnt_q - TW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rat_busy_q[i] <= 1'b0;
        rat_tag_q[i]  <= '0;
      end
      tail_q      <= TW'(1);
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      qj_q        <= '0;
      qk_q        <= '0;
      dest_q      <= '0;
      rd_q        <= '0;
      wen_q       <= 1'b0;
      pay_q       <= '0;
    end else begin
      rat_busy_q  <= rat_busy_d;
      rat_tag_q   <= rat_tag_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      dest_q      <= dest_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
      pay_q       <= pay_d;
    end
  end

  assign rnu_valid   = out_valid_q;
  assign rnu_qj      = qj_q;
  assign rnu_qk      = qk_q;
  assign rnu_dest    = dest_q;
  assign rnu_rd      = rd_q;
  assign rnu_wen     = wen_q;
  assign rnu_payload = pay_q;

  a_cmt_nonempty: assert property (@(posedge clock) disable iff (!reset)
    cmt_valid |-> cnt_q != '0);

`ifdef YSYX_RNU_PERF_EN
  logic [31:0] perf_ren_q, perf_ren_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counters survive flush; they only clear on reset and wrap naturally.
  always_comb begin
    perf_ren_d   = perf_ren_q;
    perf_stall_d = perf_stall_q;
    if (accept_c) perf_ren_d = perf_ren_q + 32'd1;
    if (idu_valid && cnt_q == TW'(ROB_SIZE)) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_ren_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ren_q   <= perf_ren_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_renamed    = perf_ren_q;
  assign perf_full_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_rnu.sv
// Self-checking bench for ysyx_rnu: directed scenarios followed by random
// traffic, all compared against a transaction-level rename model.

module tb_ysyx_rnu;

  localparam int RLEN = 5;
  localparam int XLEN = 32;
  localparam int ROB  = 8;
  localparam int PLEN = 4 * XLEN + 32;
  localparam int TW   = 4;
  localparam int NREG = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            idu_valid, idu_ready, idu_wen;
  logic [RLEN-1:0] idu_rd, idu_rs1, idu_rs2;
  logic [PLEN-1:0] idu_payload;
  logic            rnu_valid, rnu_ready, rnu_wen;
  logic [TW-1:0]   rnu_qj, rnu_qk, rnu_dest;
  logic [RLEN-1:0] rnu_rd;
  logic [PLEN-1:0] rnu_payload;
  logic            cmt_valid;
  logic [RLEN-1:0] cmt_rd;
  logic [TW-1:0]   cmt_dest;
  logic            flush;
`ifdef YSYX_RNU_PERF_EN
  logic [31:0]     perf_renamed, perf_full_stall;
`endif

  always #5 clock = ~clock;

  ysyx_rnu #(.RLEN(RLEN), .XLEN(XLEN), .ROB_SIZE(ROB), .PLEN(PLEN)) dut (
    .clock(clock), .reset(reset),
    .idu_valid(idu_valid), .idu_ready(idu_ready),
    .idu_rd(idu_rd), .idu_rs1(idu_rs1), .idu_rs2(idu_rs2),
    .idu_wen(idu_wen), .idu_payload(idu_payload),
    .rnu_valid(rnu_valid), .rnu_ready(rnu_ready),
    .rnu_qj(rnu_qj), .rnu_qk(rnu_qk), .rnu_dest(rnu_dest),
    .rnu_rd(rnu_rd), .rnu_wen(rnu_wen), .rnu_payload(rnu_payload),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_dest(cmt_dest),
    .flush(flush)
`ifdef YSYX_RNU_PERF_EN
    , .perf_renamed(perf_renamed), .perf_full_stall(perf_full_stall)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: register -> producer tag map plus an in-order list of
  // in-flight tags (the ROB as seen from rename).
  bit              m_busy [NREG];
  int              m_tag  [NREG];
  int              m_tail, m_cnt;
  int              q_tag[$];
  int              q_rd[$];
  bit              m_ov, m_wen;
  int              m_dest, m_qj, m_qk, m_rd;
  logic [PLEN-1:0] m_pay;
  int unsigned     m_ren, m_stall;

  function automatic int lookup(input int rs, input bit cv, input int cd);
    if (rs != 0 && m_busy[rs] && !(cv && cd == m_tag[rs])) return m_tag[rs];
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
    m_tail = 1; m_cnt = 0; q_tag.delete(); q_rd.delete();
    m_ov = 0; m_wen = 0; m_dest = 0; m_qj = 0; m_qk = 0; m_rd = 0; m_pay = '0;
    m_ren = 0; m_stall = 0;
  endtask

  task automatic check_out();
    check_eq("rnu_valid", rnu_valid, m_ov);
    if (m_ov) begin
      check_eq("rnu_dest", rnu_dest, m_dest);
      check_eq("rnu_qj", rnu_qj, m_qj);
      check_eq("rnu_qk", rnu_qk, m_qk);
      check_eq("rnu_rd", rnu_rd, m_rd);
      check_eq("rnu_wen", rnu_wen, m_wen);
      check_eq("rnu_payload", rnu_payload, m_pay);
    end
  endtask

  // One clock cycle: drive at negedge, check ready, advance model, check outputs.
  task automatic step(input bit v, input int rd, input int rs1, input int rs2,
                      input bit wen, input bit rr, input bit cv_req, input bit fl);
    bit cv, rdy, acc;
    int cd, crd, nqj, nqk;
    cv  = cv_req && (q_tag.size() > 0);
    cd  = cv ? q_tag[0] : 0;
    crd = cv ? q_rd[0] : 0;
    idu_valid   = v;
    idu_rd      = RLEN'(rd);
    idu_rs1     = RLEN'(rs1);
    idu_rs2     = RLEN'(rs2);
    idu_wen     = wen;
    idu_payload = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    rnu_ready   = rr;
    cmt_valid   = cv;
    cmt_rd      = RLEN'(crd);
    cmt_dest    = TW'(cd);
    flush       = fl;
    #1;
    rdy = (!m_ov || rr) && (m_cnt < ROB) && !fl;
    check_eq("idu_ready", idu_ready, rdy);
    acc = v && rdy;
    if (v && m_cnt == ROB) m_stall++;
    if (fl) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 0;
      m_cnt = 0; m_tail = 1; m_ov = 0;
      q_tag.delete(); q_rd.delete();
    end else begin
      nqj = lookup(rs1, cv, cd);
      nqk = lookup(rs2, cv, cd);
      if (cv) begin
        void'(q_tag.pop_front());
        void'(q_rd.pop_front());
        m_cnt--;
        if (m_busy[crd] && m_tag[crd] == cd) m_busy[crd] = 0;
      end
      if (acc) begin
        m_ren++;
        m_ov = 1; m_dest = m_tail; m_qj = nqj; m_qk = nqk;
        m_rd = rd; m_wen = wen; m_pay = idu_payload;
        if (wen && rd != 0) begin m_busy[rd] = 1; m_tag[rd] = m_tail; end
        q_tag.push_back(m_tail);
        q_rd.push_back(rd);
        m_tail = m_tail % ROB + 1;
        m_cnt++;
      end else if (rr) begin
        m_ov = 0;
      end
    end
    @(negedge clock);
    check_out();
  endtask

  logic [PLEN-1:0] held;

  initial begin
    reset = 1'b0; idu_valid = 0; idu_rd = '0; idu_rs1 = '0; idu_rs2 = '0;
    idu_wen = 0; idu_payload = '0; rnu_ready = 1; cmt_valid = 0; cmt_rd = '0;
    cmt_dest = '0; flush = 0;
    repeat (2) @(negedge clock);
    check_eq("ready_in_reset", idu_ready, 0);
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("rst_valid", rnu_valid, 0);
    check_eq("rst_dest", rnu_dest, 0);
    check_eq("rst_qj", rnu_qj, 0);
    check_eq("rst_qk", rnu_qk, 0);
    check_eq("rst_rd", rnu_rd, 0);
    check_eq("rst_wen", rnu_wen, 0);
    check_eq("rst_payload", rnu_payload, 0);
    check_eq("rst_ready", idu_ready, 1);

    // First rename, then back-to-back RAW on x5.
    step(1, 5, 0, 0, 1, 1, 0, 0);
    check_eq("first_dest", rnu_dest, 1);
    check_eq("first_qj", rnu_qj, 0);
    step(1, 6, 5, 5, 1, 1, 0, 0);
    check_eq("raw_dest", rnu_dest, 2);
    check_eq("raw_qj", rnu_qj, 1);
    check_eq("raw_qk", rnu_qk, 1);

    // Commit of tag 1 (x5) in the same cycle as a read of x5.
    step(1, 7, 5, 6, 1, 1, 1, 0);
    check_eq("bypass_qj", rnu_qj, 0);
    check_eq("bypass_qk", rnu_qk, 2);
    step(1, 8, 5, 0, 1, 1, 0, 0);
    check_eq("rat5_cleared_qj", rnu_qj, 0);
    check_eq("rat5_cleared_dest", rnu_dest, 4);
    step(0, 0, 0, 0, 0, 1, 0, 1);

    // Fill the ROB, stall, free one entry, and wrap the tail.
    for (int i = 0; i < ROB; i++) step(1, i + 1, 0, 0, 1, 1, 0, 0);
    check_eq("full_last_dest", rnu_dest, 8);
    check_eq("full_ready", idu_ready, 0);
    repeat (3) step(1, 9, 1, 0, 1, 1, 0, 0);
    step(1, 9, 1, 0, 1, 1, 1, 0);
    check_eq("after_cmt_ready", idu_ready, 1);
    step(1, 9, 1, 0, 1, 1, 0, 0);
    check_eq("wrap_dest", rnu_dest, 1);

    // Backpressure holds the output, then flush drops it.
    step(1, 10, 9, 0, 1, 0, 0, 0);
    held = rnu_payload;
    for (int i = 0; i < 3; i++) begin
      step(1, 11, 10, 0, 1, 0, 0, 0);
      check_eq("bp_payload_stable", rnu_payload, held);
      check_eq("bp_ready", idu_ready, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("flush_valid", rnu_valid, 0);
    step(1, 12, 10, 9, 1, 1, 0, 0);
    check_eq("post_flush_dest", rnu_dest, 1);
    check_eq("post_flush_qj", rnu_qj, 0);
    check_eq("post_flush_qk", rnu_qk, 0);

    // Random traffic over a small register window to provoke dependencies.
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);

`ifdef YSYX_RNU_PERF_EN
    check_eq("perf_renamed", perf_renamed, m_ren);
    check_eq("perf_full_stall", perf_full_stall, m_stall);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_rnu.md
# ysyx_rnu

Rename unit: the receiving end of the decode-to-rename handshake. It accepts one decoded instruction per cycle from the IDU and allocates a ROB tag for it. It looks up source-operand producer tags in a register alias table (RAT) and presents the renamed instruction to dispatch from a one-entry output register. It sits between the IDU and the ROB/issue stage, and clears RAT entries on commit and on flush.

## Interface
Parameters:
- RLEN, `YSYX_REG_LEN: architectural register index width; the RAT has 2^RLEN entries.
- XLEN, `YSYX_XLEN: data width.
- ROB_SIZE, `YSYX_ROB_SIZE: ROB entry count. TW = $clog2(ROB_SIZE)+1 is the tag width.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- idu_valid  in  1  decoded instruction valid.
- idu_ready  out  1  rename can accept this cycle.
- idu_rd, idu_rs1, idu_rs2  in  RLEN each  architectural register indices.
- idu_wen  in  1  instruction writes rd.
- idu_payload  in  all other decode fields (alu, flags, trap/tval/cause, imm, op1, op2, pnpc, inst, pc)  passed through unmodified.
- rnu_valid  out  1  renamed instruction valid.
- rnu_ready  in  1  dispatch accepts.
- rnu_qj, rnu_qk  out  TW each  producer tag of rs1/rs2; 0 means operand ready.
- rnu_dest  out  TW  allocated ROB tag, in the range 1..ROB_SIZE.
- rnu_rd, rnu_wen, rnu_payload  out  registered copies of the inputs.
- cmt_valid  in  1  ROB commits one entry.
- cmt_rd  in  RLEN  committed rd.
- cmt_dest  in  TW  committed tag.
- flush  in  1  pipeline flush (mispredict/trap).

## Operation
- State:
  - RAT entries, each {busy, tag[TW]}.
  - tail tag, range 1..ROB_SIZE.
  - in-flight counter, range 0..ROB_SIZE.
  - output register with valid bit.
- idu_ready = (!rnu_valid || rnu_ready) && count < ROB_SIZE && !flush.
- Accept (idu_valid && idu_ready):
  - qj = (rs1 != 0 && RAT[rs1].busy) ? RAT[rs1].tag : 0; qk likewise for rs2.
  - Commit bypass: if cmt_valid && cmt_dest equals the looked-up tag in the same cycle, that q is 0.
  - dest = tail. The tail then advances, wrapping ROB_SIZE -> 1. The count increments.
  - If idu_wen && rd != 0: RAT[rd] <= {1, tail}.
  - Instructions with wen=0 still consume a tag; the RAT is unchanged.
  - Output register loads the result; rnu_valid = 1.
- Output register:
  - Holds while rnu_valid && !rnu_ready; the payload stays stable.
  - Clears on rnu_ready with no new accept.
- Commit (cmt_valid):
  - If RAT[cmt_rd].busy && RAT[cmt_rd].tag == cmt_dest, clear busy.
  - The count decrements.
- Simultaneous accept writing rd and commit clearing the same rd: the accept write wins.
- Simultaneous accept and commit: the count is unchanged.
- Commit with count == 0 is a protocol violation and is flagged by an assertion.
- Flush, taking priority over everything:
  - All RAT busy bits clear; count = 0; tail = 1.
  - rnu_valid = 0; the accept is suppressed.

## Timing
- Latency: instruction accepted in cycle N -> rnu_valid in cycle N+1.
- Throughput: 1 instruction/cycle while the ROB is not full and dispatch is ready.
- RAT writes are visible to the next accepted instruction. Back-to-back RAW dependencies get the prior dest tag.
- idu_ready is combinational from rnu_valid, rnu_ready, count and flush.
- The payload is not used in any ready decision.
- Reset (reset == 0 at a clock edge) values:
  - rnu_valid = 0; all RAT entries {0, 0}; tail = 1; count = 0.
  - rnu_qj = rnu_qk = rnu_dest = 0; rnu_rd = 0; rnu_wen = 0; rnu_payload = 0.
  - The idu_ready value is 0 while reset is asserted.
- Reset mid-transfer drops the held instruction. The IDU must resend it.

## Configuration
- YSYX_RNU_PERF_EN defined adds two outputs and two 32-bit counters:
  - perf_renamed (32): increments on each accept.
  - perf_full_stall (32): increments each cycle that idu_valid && count == ROB_SIZE.
  - Both counters clear on reset and do not clear on flush. They wrap at 2^32.
- Undefined: the ports and counters are absent; functional behaviour is identical.

## Test plan
- Reset, then accept pc=0x80000000 with rd=5, rs1=0, wen=1 -> next cycle rnu_dest=1, qj=0, and RAT[5] = {1, 1}.
- Back-to-back: add x5 (tag 1), then add x6,x5,x5 -> second instruction has qj=qk=1, dest=2.
- Same-cycle bypass: x5 busy with tag 1. cmt_valid with dest=1, rd=5 in the same cycle as accepting rs1=5 -> qj=0, and RAT[5] busy clears.
- ROB full with ROB_SIZE=8 and no commits:
  - 8 accepts, then idu_ready=0.
  - One commit -> idu_ready=1 the same cycle the count becomes 7.
  - The 9th instruction gets dest=1 (wrap).
- Backpressure and flush:
  - Hold rnu_ready=0 for 3 cycles -> the output payload is stable and idu_ready=0.
  - Then pulse flush -> rnu_valid=0, the next dest is 1, and all q are 0.
- With YSYX_RNU_PERF_EN: 10 accepts and 4 full-stall cycles -> perf_renamed=10, perf_full_stall=4.
